// File: rtl/riscv_test_monitor.sv
// Watches writeback and retirement of a RISC-V core running a riscv-tests style
// program. Reports pass, fail (with the test number) or timeout, and counts cycles and retired instructions.
module riscv_test_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 500,
  parameter int unsigned EXIT_SYSCALL   = 93
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_wdata,
  input  logic        retire_valid,
  input  logic [31:0] retire_inst,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] fail_testnum,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  localparam int unsigned XLEN     = 32;
  localparam logic [4:0]  REG_GP   = 5'd3;
  localparam logic [4:0]  REG_A0   = 5'd10;
  localparam logic [4:0]  REG_A7   = 5'd17;
  localparam logic [XLEN-1:0] ECALL_INST = 32'h0000_0073;
  localparam logic [XLEN-1:0] EXIT_CODE  = XLEN'(EXIT_SYSCALL);
  localparam logic [XLEN-1:0] TMO_LAST   = XLEN'(TIMEOUT_CYCLES - 1);
  localparam logic [XLEN-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TMO
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] gp_q, a0_q, a7_q;
  logic            gp_hit, a0_hit, a7_hit;
  logic [XLEN-1:0] eff_gp, eff_a7;
  logic            exit_evt;
  logic            unused_a0;

  // x0 can never match the shadowed indices, so zero-register writes fall out naturally.
  assign gp_hit = wb_we && (wb_rd == REG_GP);
  assign a0_hit = wb_we && (wb_rd == REG_A0);
  assign a7_hit = wb_we && (wb_rd == REG_A7);

  assign eff_gp = gp_hit ? wb_wdata : gp_q;
  assign eff_a7 = a7_hit ? wb_wdata : a7_q;

  assign exit_evt = (state_q == S_RUN) && retire_valid &&
                    (retire_inst == ECALL_INST) && (eff_a7 == EXIT_CODE);

  // a0 is shadowed for hierarchical visibility only; no decision depends on it.
  assign unused_a0 = ^a0_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: exit beats timeout on the same edge; terminal states hold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable) state_d = S_RUN;
      S_RUN: begin
        if (exit_evt) begin
          state_d = (eff_gp == XLEN'(1)) ? S_PASS : S_FAIL;
        end else if (cycle_count == TMO_LAST) begin
          state_d = S_TMO;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gp_q <= '0;
      a0_q <= '0;
      a7_q <= '0;
    end else begin
      if (gp_hit) gp_q <= wb_wdata;
      if (a0_hit) a0_q <= wb_wdata;
      if (a7_hit) a7_q <= wb_wdata;
    end
  end

  // Status flags track the next state so they are valid the cycle after the deciding edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      fail_testnum  <= '0;
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      done    <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TMO);
      pass    <= (state_d == S_PASS);
      timeout <= (state_d == S_TMO);
      if ((state_q == S_RUN) && (state_d == S_FAIL)) begin
        fail_testnum <= eff_gp[XLEN-1:1];
      end
      if (state_q == S_RUN) begin
        if (cycle_count != CNT_MAX) cycle_count <= cycle_count + XLEN'(1);
        if (retire_valid && (instret_count != CNT_MAX)) begin
          instret_count <= instret_count + XLEN'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: a mode-level reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_riscv_test_monitor;

  localparam int TMO   = 500;
  localparam int EXITC = 93;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3, M_TMO = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_wdata = '0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_inst = '0;
  logic        done, pass, timeout;
  logic [30:0] fail_testnum;
  logic [31:0] cycle_count, instret_count;

  int passed = 0;
  int total  = 0;

  riscv_test_monitor #(.TIMEOUT_CYCLES(TMO), .EXIT_SYSCALL(EXITC)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .retire_valid(retire_valid), .retire_inst(retire_inst),
    .done(done), .pass(pass), .timeout(timeout), .fail_testnum(fail_testnum),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: test outcome as a mode plus architectural gp/a7 and plain counters.
  int          m_mode = M_IDLE;
  logic [31:0] m_gp = '0, m_a7 = '0;
  logic [31:0] m_cyc = '0, m_ins = '0;
  logic [30:0] m_ftn = '0;

  function automatic logic [31:0] reg_after(input logic [4:0] idx, input logic [31:0] cur);
    return (wb_we && wb_rd == idx && idx != 5'd0) ? wb_wdata : cur;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic bit is_exit();
    return m_mode == M_RUN && retire_valid && retire_inst == ECALL &&
           reg_after(5'd17, m_a7) == 32'(EXITC);
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_mode <= M_IDLE; m_gp <= '0; m_a7 <= '0;
      m_cyc <= '0; m_ins <= '0; m_ftn <= '0;
    end else begin
      m_gp <= reg_after(5'd3, m_gp);
      m_a7 <= reg_after(5'd17, m_a7);
      if (m_mode == M_IDLE && enable) m_mode <= M_RUN;
      if (m_mode == M_RUN) begin
        m_cyc <= sat_inc(m_cyc);
        if (retire_valid) m_ins <= sat_inc(m_ins);
        if (is_exit()) begin
          if (reg_after(5'd3, m_gp) == 32'd1) m_mode <= M_PASS;
          else begin
            m_mode <= M_FAIL;
            m_ftn  <= 31'(reg_after(5'd3, m_gp) >> 1);
          end
        end else if (m_cyc == 32'(TMO - 1)) begin
          m_mode <= M_TMO;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge sys_clk) begin
    check("model.done", 32'(done), 32'(m_mode >= M_PASS));
    check("model.pass", 32'(pass), 32'(m_mode == M_PASS));
    check("model.timeout", 32'(timeout), 32'(m_mode == M_TMO));
    check("model.fail_testnum", 32'(fail_testnum), 32'(m_ftn));
    check("model.cycle_count", cycle_count, m_cyc);
    check("model.instret_count", instret_count, m_ins);
  end

  task automatic tick(input logic en, input logic we, input logic [4:0] rd,
                      input logic [31:0] wd, input logic rv, input logic [31:0] inst);
    enable = en; wb_we = we; wb_rd = rd; wb_wdata = wd;
    retire_valid = rv; retire_inst = inst;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] wd);
    tick(1'b0, 1'b1, rd, wd, 1'b1, NOP);
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    enable = 0; wb_we = 0; wb_rd = 0; wb_wdata = 0; retire_valid = 0; retire_inst = 0;
    #3;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic expect_flags(input string tag, input logic d, input logic p, input logic t,
                              input logic [30:0] ftn);
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".pass"}, 32'(pass), 32'(p));
    check({tag, ".timeout"}, 32'(timeout), 32'(t));
    check({tag, ".fail_testnum"}, 32'(fail_testnum), 32'(ftn));
  endtask

  initial begin
    #1 sys_rst_n = 1'b0;
    #12;
    expect_flags("reset", 0, 0, 0, 0);
    check("reset.cycle_count", cycle_count, 0);
    check("reset.instret_count", instret_count, 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;

    // Pass flow, preceded by an ecall in IDLE that must be ignored.
    idle(3);
    check("idle.cycle_count", cycle_count, 0);
    wr(5'd17, 32'd93);
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, ECALL);
    expect_flags("idle_ecall", 0, 0, 0, 0);
    check("idle_ecall.instret", instret_count, 0);
    tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    wr(5'd3, 32'd1); wr(5'd17, 32'd93); wr(5'd10, 32'd0);
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, ECALL);
    expect_flags("pass", 1, 1, 0, 0);
    check("pass.instret", instret_count, 4);
    check("pass.cycles", cycle_count, 4);
    idle(2);
    check("pass.frozen_cycles", cycle_count, 4);

    // Fail flow, then a later passing ecall that must not change anything.
    do_reset();
    tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    wr(5'd3, 32'h0000_000B); wr(5'd17, 32'd93);
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, ECALL);
    expect_flags("fail", 1, 0, 0, 31'd5);
    wr(5'd3, 32'd1);
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, ECALL);
    expect_flags("fail.sticky", 1, 0, 0, 31'd5);
    check("fail.instret", instret_count, 3);

    // Same-cycle gp writeback bypasses into the exit decision.
    do_reset();
    wr(5'd17, 32'd93);
    tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    tick(1'b0, 1'b1, 5'd3, 32'd1, 1'b1, ECALL);
    expect_flags("bypass_pass", 1, 1, 0, 0);

    // gp=1 arriving one cycle late does not rescue an ecall that saw gp=3.
    do_reset();
    tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    wr(5'd17, 32'd93); wr(5'd3, 32'd3);
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, ECALL);
    wr(5'd3, 32'd1);
    expect_flags("late_gp", 1, 0, 0, 31'd1);

    // x0 writes, non-exit syscalls and ebreak are ordinary instructions.
    do_reset();
    tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    wr(5'd3, 32'd1);
    wr(5'd0, 32'd5);
    wr(5'd17, 32'd64);
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, ECALL);
    wr(5'd17, 32'd93);
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, EBREAK);
    expect_flags("ignored", 0, 0, 0, 0);
    check("ignored.instret", instret_count, 6);

    // Timeout with no exit.
    do_reset();
    tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    idle(TMO - 1);
    check("tmo.before_cycles", cycle_count, 32'(TMO - 1));
    check("tmo.before_done", 32'(done), 0);
    idle(1);
    expect_flags("tmo", 1, 0, 1, 0);
    check("tmo.cycles", cycle_count, 32'(TMO));
    idle(3);
    check("tmo.frozen", cycle_count, 32'(TMO));

    // Exit on the timeout edge wins.
    do_reset();
    wr(5'd3, 32'd1); wr(5'd17, 32'd93);
    tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    idle(TMO - 1);
    tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, ECALL);
    expect_flags("tie", 1, 1, 0, 0);

    // Asynchronous reset mid-run, then a fresh run restarts the counters.
    do_reset();
    tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, NOP);
    check("midrun.cycles", cycle_count, 100);
    #2 sys_rst_n = 1'b0;
    #1;
    expect_flags("midrun_rst", 0, 0, 0, 0);
    check("midrun_rst.cycles", cycle_count, 0);
    check("midrun_rst.instret", instret_count, 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    idle(2);
    check("rerun.idle_cycles", cycle_count, 0);
    tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    idle(3);
    check("rerun.cycles", cycle_count, 3);

    idle(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/riscv_test_monitor.md
RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500, cycles in RUN before a timeout is declared.
REQ-002 SHALL have parameter EXIT_SYSCALL, default 93, the a7 value that marks a test-exit ecall.
REQ-003 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  start monitoring; sampled in IDLE only.
REQ-006 wb_we  input  1  register-file write strobe from writeback.
REQ-007 wb_rd  input  5  writeback destination register index.
REQ-008 wb_wdata  input  32  writeback data.
REQ-009 retire_valid  input  1  one instruction retires this cycle.
REQ-010 retire_inst  input  32  encoding of the retiring instruction.
REQ-011 done  output  1  test finished (pass, fail or timeout); sticky.
REQ-012 pass  output  1  test passed; sticky.
REQ-013 timeout  output  1  timeout expired before exit; sticky.
REQ-014 fail_testnum  output  31  failing test number (gp[31:1]); 0 unless failed.
REQ-015 cycle_count  output  32  cycles spent in RUN.
REQ-016 instret_count  output  32  instructions retired in RUN.

Function
REQ-017 SHALL implement states IDLE, RUN, PASS, FAIL, TMO; the encoding is free.
REQ-018 IDLE -> RUN on the first edge with enable=1; enable is ignored in all other states.
REQ-019 Shadow registers gp (x3), a0 (x10), a7 (x17) SHALL load wb_wdata when wb_we=1 and wb_rd matches; they update in every state.
REQ-020 wb_we with wb_rd=0 SHALL be ignored; writes to other indices SHALL be ignored.
REQ-021 Exit event = RUN and retire_valid=1 and retire_inst==32'h00000073 (ecall) and effective a7==EXIT_SYSCALL.
REQ-022 Effective gp/a7 SHALL bypass a same-cycle writeback to that register; it equals wb_wdata when a write hits.
REQ-023 On an exit event with effective gp==1: RUN -> PASS.
REQ-024 On an exit event with effective gp!=1: RUN -> FAIL, and fail_testnum latches effective gp[31:1].
REQ-025 An ecall with a7!=EXIT_SYSCALL SHALL retire as a normal instruction with no state change; ebreak is not an exit.
REQ-026 In RUN, cycle_count SHALL increment by 1 every cycle and saturate at 32'hFFFFFFFF.
REQ-027 In RUN, instret_count SHALL increment by 1 per retire_valid, including the exit ecall, and saturate.
REQ-028 RUN -> TMO when cycle_count==TIMEOUT_CYCLES-1 at the edge and there is no exit event.
REQ-029 When an exit event and timeout expiry fall on the same cycle, the exit event SHALL win.
REQ-030 PASS, FAIL and TMO SHALL be terminal until reset; counters freeze and later ecalls are ignored.
REQ-031 done = state in {PASS, FAIL, TMO}; pass = (state==PASS); timeout = (state==TMO); all are registered.
REQ-032 Latency: done asserts on the first cycle after the edge that samples the exit ecall.
REQ-033 There is no X propagation; retire_inst SHALL be qualified by retire_valid.

Reset
REQ-034 On sys_rst_n=0, asynchronously: state=IDLE, and done, pass, timeout, fail_testnum, cycle_count, instret_count, gp, a0 and a7 all 0.
REQ-035 Reset asserted mid-RUN or in a terminal state SHALL abort immediately to IDLE with all outputs 0.
REQ-036 After reset release, the block stays in IDLE with counters 0 until enable=1.

Verification
REQ-037 Pass: enable; write x3=1, x17=93, x10=0; retire 0x00000073 -> next cycle done=1, pass=1, fail_testnum=0, instret_count=4.
REQ-038 Fail: write x3=0x0000000B, x17=93; retire ecall -> done=1, pass=0, fail_testnum=5; a later ecall with x3=1 leaves the state FAIL.
REQ-039 Bypass: in the same cycle, wb x3=1 and retire ecall with x17=93 already set -> PASS; x3=1 arriving the cycle after an ecall carrying x3=3 -> FAIL, fail_testnum=1.
REQ-040 Timeout: TIMEOUT_CYCLES=500, enable, no ecall -> timeout=1 and done=1 after cycle_count reaches 499; an exit ecall on that same cycle -> PASS instead.
REQ-041 Ignored events: wb x0=5, an ecall with x17=64, and ecall while in IDLE -> no state change, and instret_count counts only RUN retires.
REQ-042 Reset: assert sys_rst_n=0 mid-RUN at cycle 100 -> all outputs 0 at once and state IDLE; re-enable restarts cycle_count from 0.
